// File: rtl/linebuf_pkg.sv
// Shared types and width helpers for the line-buffer sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package linebuf_pkg;

    // Frame-level sequencer states
    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH
    } seq_state_t;

    // Synthetic flush-line generator states
    typedef enum logic [1:0] {
        FG_IDLE,
        FG_GAP,
        FG_LINE
    } flush_state_t;

    // Bits needed to count 0..n-1 (never less than one bit)
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Column counter width: 0..width-1
    function automatic int col_w(input int width);
        return cnt_w(width);
    endfunction

    // Row counter width: must reach height+depth-2 while flush lines drain
    function automatic int row_w(input int height, input int depth);
        return cnt_w(height + depth - 1);
    endfunction

endpackage

// File: rtl/linebuf_flush_gen.sv
// Generates synthetic end-of-frame lines: gap cycles, then a full line of dv.
// Latency: outputs are decoded from registered state; first dv FLUSH_GAP cycles after start.
// Backpressure: none; abort_i returns it to idle at the next edge.
module linebuf_flush_gen
    import linebuf_pkg::*;
#(
    parameter int SCREENWIDTH = 1600,
    parameter int FLUSH_GAP   = 16,
    parameter int LINES_W     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [LINES_W-1:0] lines_i,
    output logic               dv_o,
    output logic               line_end_o,
    output logic               done_o
);

    localparam int CW = col_w(SCREENWIDTH);
    localparam int GW = cnt_w(FLUSH_GAP);

    flush_state_t       state_q, state_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [CW-1:0]      pix_q, pix_d;
    logic [LINES_W-1:0] line_q, line_d;

    // Next-state: gap countdown, pixel run, line accounting
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        pix_d      = pix_q;
        line_d     = line_q;
        dv_o       = 1'b0;
        line_end_o = 1'b0;
        done_o     = 1'b0;

        case (state_q)
            FG_IDLE: begin
            end
            FG_GAP: begin
                if (gap_q == GW'(FLUSH_GAP - 1)) begin
                    state_d = FG_LINE;
                    pix_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            FG_LINE: begin
                dv_o  = 1'b1;
                pix_d = pix_q + 1'b1;
                if (pix_q == CW'(SCREENWIDTH - 1)) begin
                    line_end_o = 1'b1;
                    pix_d      = '0;
                    gap_d      = '0;
                    if (line_q == lines_i - LINES_W'(1)) begin
                        done_o  = 1'b1;
                        state_d = FG_IDLE;
                    end else begin
                        line_d = line_q + 1'b1;
                        if (FLUSH_GAP == 0) state_d = FG_LINE;
                        else                state_d = FG_GAP;
                    end
                end
            end
            default: state_d = FG_IDLE;
        endcase

        if (start_i) begin
            gap_d  = '0;
            pix_d  = '0;
            line_d = '0;
            if (FLUSH_GAP == 0) state_d = FG_LINE;
            else                state_d = FG_GAP;
        end

        if (abort_i) begin
            state_d = FG_IDLE;
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FG_IDLE;
            gap_q   <= '0;
            pix_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
        end
    end

endmodule

// File: rtl/linebuf_seq.sv
// Frame sequencer driving the line buffer; tracks row/col, primes window, flushes at frame end. Optional stats: LINEBUF_SEQ_STATS_EN.
// Latency: buf_* outputs one cycle after the input pixel; win_* one cycle after buf_dv_o.
// Backpressure: none; overlong-line pixels and pixels during flush are dropped and flagged.
module linebuf_seq
    import linebuf_pkg::*;
#(
    parameter int COLORDEPTH   = 8,
    parameter int SCREENWIDTH  = 1600,
    parameter int SCREENHEIGHT = 900,
    parameter int BUF_DEPTH    = 3,
    parameter int FLUSH_GAP    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              vs_i,
    input  logic                              dv_i,
    input  logic [COLORDEPTH-1:0]             data_i,
    output logic [COLORDEPTH-1:0]             buf_data_o,
    output logic                              buf_dv_o,
    output logic                              buf_line_end_o,
    output logic                              win_valid_o,
    output logic [cnt_w(SCREENHEIGHT)-1:0]    win_row_o,
    output logic [col_w(SCREENWIDTH)-1:0]     win_col_o,
`ifdef LINEBUF_SEQ_STATS_EN
    output logic [15:0]                       frame_cnt_o,
    output logic [15:0]                       err_cnt_o,
    output logic [col_w(SCREENWIDTH):0]       last_len_o,
`endif
    output logic                              busy_o,
    output logic                              sync_err_o,
    output logic                              len_err_o
);

    localparam int CW  = col_w(SCREENWIDTH);
    localparam int RW  = row_w(SCREENHEIGHT, BUF_DEPTH);
    localparam int WRW = cnt_w(SCREENHEIGHT);
    localparam int LW  = cnt_w(BUF_DEPTH);

    localparam logic [CW-1:0] LAST_COL  = CW'(SCREENWIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(SCREENHEIGHT - 1);
    localparam logic [RW-1:0] FILL_ROWS = RW'(BUF_DEPTH - 1);
    localparam logic [RW-1:0] FILL_LAST = RW'(BUF_DEPTH - 2);

    seq_state_t            state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  gap_req_q, gap_req_d;
    logic                  err_seen_q, err_seen_d;
    logic [COLORDEPTH-1:0] buf_data_q, buf_data_d;
    logic                  buf_dv_q, buf_dv_d;
    logic                  buf_le_q, buf_le_d;
    logic [RW-1:0]         buf_row_q, buf_row_d;
    logic [CW-1:0]         buf_col_q, buf_col_d;
    logic                  win_valid_q, win_valid_d;
    logic [WRW-1:0]        win_row_q, win_row_d;
    logic [CW-1:0]         win_col_q, win_col_d;
    logic                  len_err_q, len_err_d;
    logic                  sync_err_q, sync_err_d;
    logic                  line_done;
    logic                  flush_start;
    logic                  flush_abort;
    logic                  fg_dv;
    logic                  fg_le;
    logic                  fg_done;

    linebuf_flush_gen #(
        .SCREENWIDTH (SCREENWIDTH),
        .FLUSH_GAP   (FLUSH_GAP),
        .LINES_W     (LW)
    ) u_flush (
        .clk        (clk),
        .rst        (rst),
        .start_i    (flush_start),
        .abort_i    (flush_abort),
        .lines_i    (LW'(BUF_DEPTH - 1)),
        .dv_o       (fg_dv),
        .line_end_o (fg_le),
        .done_o     (fg_done)
    );

    // Sequencer: pixel forwarding, line-length policing, row/col tracking, state moves
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        gap_req_d   = gap_req_q;
        err_seen_d  = err_seen_q;
        buf_data_d  = '0;
        buf_dv_d    = 1'b0;
        buf_le_d    = 1'b0;
        buf_row_d   = row_q;
        buf_col_d   = col_q;
        len_err_d   = 1'b0;
        sync_err_d  = 1'b0;
        line_done   = 1'b0;
        flush_start = 1'b0;
        flush_abort = 1'b0;

        case (state_q)
            IDLE: begin
            end
            FILL, RUN: begin
                if (dv_i) begin
                    if (gap_req_q) begin
                        // Line already ended without a dv gap: drop, report once
                        len_err_d  = ~err_seen_q;
                        err_seen_d = 1'b1;
                    end else begin
                        buf_dv_d   = 1'b1;
                        buf_data_d = data_i;
                        if (col_q == LAST_COL) begin
                            buf_le_d   = 1'b1;
                            col_d      = '0;
                            gap_req_d  = 1'b1;
                            err_seen_d = 1'b0;
                            line_done  = 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end else begin
                    gap_req_d  = 1'b0;
                    err_seen_d = 1'b0;
                    // Short line: counted as complete, buffer resets on dv low
                    if (col_q != '0) begin
                        len_err_d = 1'b1;
                        col_d     = '0;
                        line_done = 1'b1;
                    end
                end

                if (line_done) begin
                    row_d = row_q + 1'b1;
                    if (state_q == FILL && row_q == FILL_LAST) begin
                        state_d = RUN;
                    end
                    if (state_q == RUN && row_q == LAST_ROW) begin
                        state_d     = FLUSH;
                        flush_start = 1'b1;
                    end
                end
            end
            FLUSH: begin
                len_err_d = dv_i;
                if (fg_dv) begin
                    buf_dv_d = 1'b1;
                    if (fg_le) begin
                        buf_le_d = 1'b1;
                        col_d    = '0;
                        row_d    = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                if (fg_done) begin
                    state_d = IDLE;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame start wins over everything, including a coincident line end
        if (vs_i) begin
            sync_err_d  = (state_q != IDLE);
            len_err_d   = 1'b0;
            state_d     = FILL;
            col_d       = '0;
            row_d       = '0;
            buf_dv_d    = 1'b0;
            buf_le_d    = 1'b0;
            buf_data_d  = '0;
            gap_req_d   = dv_i;
            err_seen_d  = dv_i;
            line_done   = 1'b0;
            flush_start = 1'b0;
            flush_abort = 1'b1;
        end
    end

    // Window stage: one cycle behind the buffer drive, only once the window is primed
    always_comb begin
        win_valid_d = buf_dv_q && (buf_row_q >= FILL_ROWS);
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        if (win_valid_d) begin
            win_row_d = WRW'(buf_row_q - FILL_ROWS);
            win_col_d = buf_col_q;
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            gap_req_q   <= 1'b0;
            err_seen_q  <= 1'b0;
            buf_data_q  <= '0;
            buf_dv_q    <= 1'b0;
            buf_le_q    <= 1'b0;
            buf_row_q   <= '0;
            buf_col_q   <= '0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            len_err_q   <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            gap_req_q   <= gap_req_d;
            err_seen_q  <= err_seen_d;
            buf_data_q  <= buf_data_d;
            buf_dv_q    <= buf_dv_d;
            buf_le_q    <= buf_le_d;
            buf_row_q   <= buf_row_d;
            buf_col_q   <= buf_col_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            len_err_q   <= len_err_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign buf_data_o     = buf_data_q;
    assign buf_dv_o       = buf_dv_q;
    assign buf_line_end_o = buf_le_q;
    assign win_valid_o    = win_valid_q;
    assign win_row_o      = win_row_q;
    assign win_col_o      = win_col_q;
    assign busy_o         = (state_q != IDLE);
    assign sync_err_o     = sync_err_q;
    assign len_err_o      = len_err_q;

`ifdef LINEBUF_SEQ_STATS_EN
    localparam logic [CW:0] FULL_LEN = (CW + 1)'(SCREENWIDTH);

    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [CW:0] last_len_q, last_len_d;

    // Stats: completed frames (wrap), error events (saturate), last line length
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        last_len_d  = last_len_q;
        if (state_q == FLUSH && state_d == IDLE) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if ((sync_err_d || len_err_d) && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
        if (line_done) begin
            last_len_d = buf_le_d ? FULL_LEN : {1'b0, col_q};
        end
    end

    // Stats registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            last_len_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            last_len_q  <= last_len_d;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign err_cnt_o   = err_cnt_q;
    assign last_len_o  = last_len_q;
`endif

endmodule

// File: tb/tb_linebuf_seq.sv
// Scoreboard bench for linebuf_seq with a small 8x4 frame, 3-line window, 2-cycle flush gap.
// Stimulus pushes expected buffer pixels and window coordinates; a negedge monitor pops and compares.
// Per-test totals (dv, line_end, window, error pulses) are checked by the monitor on request.
module tb_linebuf_seq;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int BD = 3;
    localparam int FG = 2;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       vs_i   = 1'b0;
    logic       dv_i   = 1'b0;
    logic [7:0] data_i = 8'd0;

    logic [7:0] buf_data_o;
    logic       buf_dv_o;
    logic       buf_line_end_o;
    logic       win_valid_o;
    logic [1:0] win_row_o;
    logic [2:0] win_col_o;
    logic       busy_o;
    logic       sync_err_o;
    logic       len_err_o;
`ifdef LINEBUF_SEQ_STATS_EN
    logic [15:0] frame_cnt_o;
    logic [15:0] err_cnt_o;
    logic [3:0]  last_len_o;
`endif

    linebuf_seq #(
        .COLORDEPTH   (8),
        .SCREENWIDTH  (W),
        .SCREENHEIGHT (H),
        .BUF_DEPTH    (BD),
        .FLUSH_GAP    (FG)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .vs_i           (vs_i),
        .dv_i           (dv_i),
        .data_i         (data_i),
        .buf_data_o     (buf_data_o),
        .buf_dv_o       (buf_dv_o),
        .buf_line_end_o (buf_line_end_o),
        .win_valid_o    (win_valid_o),
        .win_row_o      (win_row_o),
        .win_col_o      (win_col_o),
`ifdef LINEBUF_SEQ_STATS_EN
        .frame_cnt_o    (frame_cnt_o),
        .err_cnt_o      (err_cnt_o),
        .last_len_o     (last_len_o),
`endif
        .busy_o         (busy_o),
        .sync_err_o     (sync_err_o),
        .len_err_o      (len_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       le;
    } pix_t;

    typedef struct packed {
        logic [1:0] row;
        logic [2:0] col;
    } win_t;

    pix_t qpix[$];
    win_t qwin[$];

    int n_vec = 0;
    int n_err = 0;
    int n_pix = 0, n_le = 0, n_win = 0, n_len = 0, n_sync = 0;
    int exp_pix = 0, exp_le = 0, exp_win = 0, exp_len = 0, exp_sync = 0;
    int cur_test = 0;
    logic end_chk = 1'b0;
    logic rst_chk = 1'b0;
    logic tmo     = 1'b0;

    function automatic void check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL t%0d %s: got %0d, want %0d", cur_test, name, act, req);
        end
    endfunction

    // Monitor: scoreboard pops on every DUT output, plus on-request totals
    always @(negedge clk) begin
        pix_t e;
        win_t w;
        check("line_end_without_dv", int'(buf_line_end_o & ~buf_dv_o), 0);
        if (buf_dv_o) begin
            n_pix++;
            if (buf_line_end_o) n_le++;
            check("pixel_expected", int'(qpix.size() != 0), 1);
            if (qpix.size() != 0) begin
                e = qpix.pop_front();
                check("pix_data", int'(buf_data_o), int'(e.d));
                check("pix_line_end", int'(buf_line_end_o), int'(e.le));
            end
        end
        if (win_valid_o) begin
            n_win++;
            check("window_expected", int'(qwin.size() != 0), 1);
            if (qwin.size() != 0) begin
                w = qwin.pop_front();
                check("win_row", int'(win_row_o), int'(w.row));
                check("win_col", int'(win_col_o), int'(w.col));
            end
        end
        if (len_err_o)  n_len++;
        if (sync_err_o) n_sync++;
        if (rst_chk) begin
            check("rst_buf_outputs", int'({buf_data_o, buf_dv_o, buf_line_end_o}), 0);
            check("rst_win_outputs", int'({win_valid_o, win_row_o, win_col_o}), 0);
            check("rst_busy_err", int'({busy_o, sync_err_o, len_err_o}), 0);
        end
        if (end_chk) begin
            check("drain_timeout", int'(tmo), 0);
            check("pixels_left", qpix.size(), 0);
            check("windows_left", qwin.size(), 0);
            check("buf_dv_count", n_pix, exp_pix);
            check("line_end_count", n_le, exp_le);
            check("win_valid_count", n_win, exp_win);
            check("len_err_count", n_len, exp_len);
            check("sync_err_count", n_sync, exp_sync);
            check("busy_at_end", int'(busy_o), 0);
            qpix.delete();
            qwin.delete();
            n_pix = 0; n_le = 0; n_win = 0; n_len = 0; n_sync = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_line(input int n, input int v0);
        for (int i = 0; i < n; i++) begin
            dv_i   = 1'b1;
            data_i = 8'(v0 + i);
            tick();
        end
        dv_i   = 1'b0;
        data_i = 8'd0;
    endtask

    task automatic vs_pulse();
        vs_i = 1'b1;
        tick();
        vs_i = 1'b0;
    endtask

    // n forwarded pixels of input row 'row'; first nw of them reach the window output
    task automatic exp_line(input int v0, input int n, input int row, input int nw);
        pix_t p;
        win_t w;
        for (int i = 0; i < n; i++) begin
            p.d  = 8'(v0 + i);
            p.le = (i == W - 1);
            qpix.push_back(p);
            if (row >= BD - 1 && i < nw) begin
                w.row = 2'(row - (BD - 1));
                w.col = 3'(i);
                qwin.push_back(w);
            end
        end
    endtask

    task automatic exp_flush();
        pix_t p;
        win_t w;
        for (int r = H; r < H + BD - 1; r++) begin
            for (int i = 0; i < W; i++) begin
                p.d   = 8'd0;
                p.le  = (i == W - 1);
                w.row = 2'(r - (BD - 1));
                w.col = 3'(i);
                qpix.push_back(p);
                qwin.push_back(w);
            end
        end
    endtask

    task automatic exp_frame(input int v0);
        for (int r = 0; r < H; r++) exp_line(v0 + 8 * r, W, r, W);
        exp_flush();
    endtask

    task automatic run_frame(input int v0);
        for (int r = 0; r < H; r++) begin
            send_line(W, v0 + 8 * r);
            idle(3);
        end
    endtask

    task automatic end_test(input int p, input int le, input int wn, input int ln, input int sy);
        exp_pix  = p;
        exp_le   = le;
        exp_win  = wn;
        exp_len  = ln;
        exp_sync = sy;
        tmo      = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (!busy_o && qpix.size() == 0 && qwin.size() == 0) begin
                tmo = 1'b0;
                break;
            end
            tick();
        end
        idle(3);
        end_chk = 1'b1;
        tick();
        end_chk = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b0;
        idle(3);
        rst_chk = 1'b1;
        tick();
        rst_chk = 1'b0;
        rst = 1'b1;
        tick();

        // 1: clean frame, 4 lines of 8 with 3-cycle gaps
        cur_test = 1;
        exp_frame(1);
        vs_pulse();
        run_frame(1);
        end_test(48, 6, 32, 0, 0);

        // 2: second line only 5 pixels
        cur_test = 2;
        exp_line(41, 8, 0, 8);
        exp_line(49, 5, 1, 5);
        exp_line(57, 8, 2, 8);
        exp_line(65, 8, 3, 8);
        exp_flush();
        vs_pulse();
        send_line(8, 41); idle(3);
        send_line(5, 49); idle(3);
        send_line(8, 57); idle(3);
        send_line(8, 65); idle(3);
        end_test(45, 5, 32, 1, 0);

        // 3: first line 11 contiguous pixels, last 3 dropped
        cur_test = 3;
        exp_line(1, 8, 0, 8);
        exp_line(21, 8, 1, 8);
        exp_line(29, 8, 2, 8);
        exp_line(37, 8, 3, 8);
        exp_flush();
        vs_pulse();
        send_line(11, 1); idle(3);
        send_line(8, 21); idle(3);
        send_line(8, 29); idle(3);
        send_line(8, 37); idle(3);
        end_test(48, 6, 32, 1, 0);

        // 4: vs during the third line restarts the frame
        cur_test = 4;
        exp_line(1, 8, 0, 8);
        exp_line(9, 8, 1, 8);
        exp_line(17, 4, 2, 4);
        exp_frame(101);
        vs_pulse();
        send_line(8, 1); idle(3);
        send_line(8, 9); idle(3);
        send_line(4, 17);
        vs_i   = 1'b1;
        dv_i   = 1'b1;
        data_i = 8'd21;
        tick();
        vs_i = 1'b0;
        send_line(3, 22);
        idle(3);
        run_frame(101);
        end_test(68, 8, 36, 0, 1);

        // 5: dv pulse while flushing is dropped and flagged
        cur_test = 5;
        exp_frame(1);
        vs_pulse();
        run_frame(1);
        dv_i   = 1'b1;
        data_i = 8'h55;
        tick();
        dv_i   = 1'b0;
        data_i = 8'd0;
        end_test(48, 6, 32, 1, 0);

        // 6: reset in the middle of RUN, then dv ignored without vs
        cur_test = 6;
        exp_line(1, 8, 0, 8);
        exp_line(9, 8, 1, 8);
        exp_line(17, 4, 2, 3);
        vs_pulse();
        send_line(8, 1); idle(3);
        send_line(8, 9); idle(3);
        send_line(4, 17);
        rst    = 1'b0;
        dv_i   = 1'b1;
        data_i = 8'd21;
        tick();
        rst     = 1'b1;
        rst_chk = 1'b1;
        data_i  = 8'd22;
        tick();
        rst_chk = 1'b0;
        send_line(2, 23);
        idle(3);
        send_line(8, 30);
        idle(3);
        end_test(20, 2, 3, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/linebuf_seq.md
Name: linebuf_seq

Overview:
Frame-level sequencer for the line-buffer window datapath. It takes raw pixel valid/data from the video front end and produces the buffer's `data_i`/`dv_i`/`line_end` drive. It tracks row and column position and declares when the BUF_DEPTH-line window is primed. At frame end it injects synthetic flush lines so the last rows of a frame drain out of the buffer.

Parameters:
- COLORDEPTH, 8: pixel width.
- SCREENWIDTH, 1600: active pixels per line.
- SCREENHEIGHT, 900: active lines per frame.
- BUF_DEPTH, 3: window height (must match the buffer instance).
- FLUSH_GAP, 16: blank cycles inserted before each synthetic flush line.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-low reset.
- vs_i, input, 1: one-cycle frame-start pulse.
- dv_i, input, 1: input pixel valid.
- data_i, input, COLORDEPTH: input pixel.
- buf_data_o, output, COLORDEPTH: to buffer `data_i`.
- buf_dv_o, output, 1: to buffer `dv_i`.
- buf_line_end_o, output, 1: to buffer `line_end`.
- win_valid_o, output, 1: buffer window outputs hold a complete column.
- win_row_o, output, $clog2(SCREENHEIGHT): output row of the window bottom.
- win_col_o, output, $clog2(SCREENWIDTH): column of the current window.
- busy_o, output, 1: state is not IDLE.
- sync_err_o, output, 1: one-cycle pulse when `vs_i` arrives mid-frame.
- len_err_o, output, 1: one-cycle pulse on a line-length violation.

Behaviour:
- Reset (`rst`=0 at posedge): state IDLE, all counters 0, all outputs 0.
- Output latency: every `buf_*` output is registered, one cycle after the qualifying input.
- States:
  - IDLE: ignores `dv_i`. `vs_i` -> FILL with col=0, row=0.
  - FILL: forwards pixels. After BUF_DEPTH-1 completed lines -> RUN.
  - RUN: forwards pixels. After line SCREENHEIGHT-1 completes -> FLUSH.
  - FLUSH: emits BUF_DEPTH-1 synthetic lines. Each line is FLUSH_GAP idle cycles, then SCREENWIDTH cycles with `buf_dv_o`=1 and `buf_data_o`=0. Then -> IDLE.
- Column counter:
  - Increments on each forwarded pixel.
  - `buf_line_end_o`=1 together with the pixel at col==SCREENWIDTH-1; col then wraps to 0 and row increments.
- Short line (`dv_i` falls with 0 < col < SCREENWIDTH):
  - The line is counted as complete: row increments, col resets.
  - `len_err_o` pulses.
  - No `buf_line_end_o` is emitted; the buffer resets its address on `dv` low.
- Long line (`dv_i` still high after a line end, with no dv gap):
  - The excess pixels are dropped (`buf_dv_o`=0).
  - `len_err_o` pulses once per line.
  - The next line starts only after `dv_i` has been low for at least 1 cycle.
- Window timing:
  - The buffer adds 1 cycle of latency, so `win_valid_o` = `buf_dv_o` delayed 1 cycle, gated by row ≥ BUF_DEPTH-1 (RUN and FLUSH lines only).
  - `win_row_o` = line index − (BUF_DEPTH-1); `win_col_o` = pixel column. Both are delayed to align with `win_valid_o`.
- `vs_i` outside IDLE:
  - Pulse `sync_err_o`.
  - Clear the counters and enter FILL, dropping the partial frame.
  - `vs_i` takes priority over a simultaneous line end.
- `dv_i` during FLUSH: dropped, and `len_err_o` pulses.
- Reset mid-frame: immediate return to IDLE. Any pending `win_valid_o` pipeline stage is cleared.
- Counter arithmetic is unsigned and sized with $clog2. Row never exceeds SCREENHEIGHT+BUF_DEPTH-2.

Optional Feature:
- Macro: LINEBUF_SEQ_STATS_EN.
- When defined, three output ports are added:
  - frame_cnt_o, 16 bits: frames completed through FLUSH; wraps.
  - err_cnt_o, 16 bits: `sync_err` plus `len_err` events; saturates at 0xFFFF.
  - Both counters clear on reset.
  - last_len_o, $clog2(SCREENWIDTH)+1 bits: pixel count of the most recent input line.
- When undefined, these ports and registers are absent and the remaining behaviour is identical.

Decomposition:
- Package `linebuf_pkg`:
  - state enum `seq_state_t` {IDLE, FILL, RUN, FLUSH}.
  - width helper functions for the col/row counters.
- Sub-module `linebuf_flush_gen`: gap counter plus synthetic-line generator. Inputs: start, line count. Outputs: dv, line_end, done.

Test Plan (SCREENWIDTH=8, SCREENHEIGHT=4, BUF_DEPTH=3, FLUSH_GAP=2):
1. Reset released, `vs_i` pulse, 4 lines of 8 pixels (values 1..32) with 3-cycle gaps:
   - `buf_dv_o` count = 32 + 16 flush.
   - `buf_line_end_o` = 6 pulses.
   - `win_valid_o` = 32 cycles with `win_row_o` 0..3.
   - `busy_o` falls after flush.
2. Line 2 only 5 pixels:
   - `len_err_o` pulses once.
   - Row still advances; the frame completes normally with 4 output rows.
3. Line 1 with 11 contiguous pixels:
   - Pixels 9..11 are not forwarded.
   - One `len_err_o` pulse; next line accepted after the dv gap.
4. `vs_i` during line 3:
   - `sync_err_o` pulse; row restarts at 0.
   - No `win_valid_o` until 2 new lines are complete.
5. `dv_i` pulsed during FLUSH:
   - Dropped, `len_err_o` pulses.
   - Flush still emits exactly 16 zero pixels.
6. `rst`=0 asserted mid-RUN:
   - Next cycle all outputs 0 and `busy_o`=0.
   - `dv_i` ignored until `vs_i`.
